// File: rtl/spislaveio_pkg.sv
// spislave_pkg: register map, status/control bit positions and FSM encoding for spislaveio.
package spislave_pkg;
    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_CTRL    = 3'd2;
    localparam logic [2:0] A_FILL    = 3'd3;
    localparam logic [2:0] A_BYTECNT = 3'd4;
    localparam int S_RXF  = 0;
    localparam int S_TXE  = 1;
    localparam int S_OVR  = 2;
    localparam int S_UDR  = 3;
    localparam int S_SEL  = 4;
    localparam int S_BUSY = 5;
    localparam int S_EOF  = 6;
    localparam int C_RXIE  = 0;
    localparam int C_TXIE  = 1;
    localparam int C_EOFIE = 2;
    localparam int C_EN    = 7;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spislaveio_if.sv
// spislaveio_if: CPU register bus plus SPI pins of the SPI responder.
interface spislaveio_if;
    logic [2:0] i_ad;
    logic [7:0] i_di;
    logic [7:0] o_do;
    logic       i_rw;
    logic       i_cs;
    logic       o_irq;
    logic       i_ss_n;
    logic       i_sck;
    logic       i_mosi;
    logic       o_miso;
    logic       o_miso_oe;
    modport slave (input i_ad, i_di, i_rw, i_cs, i_ss_n, i_sck, i_mosi,
                   output o_do, o_irq, o_miso, o_miso_oe);
    modport master (output i_ad, i_di, i_rw, i_cs, i_ss_n, i_sck, i_mosi,
                    input o_do, o_irq, o_miso, o_miso_oe);
endinterface

// File: rtl/spislaveio_syncedge.sv
// syncedge: multi-flop synchronizer with registered rise/fall pulses.
module syncedge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end
    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/spislaveio.sv
// spislaveio: SPI mode-0 responder with CPU register window and TX/RX holding buffers.
module spislaveio
    import spislave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_RESET  = 8'hFF
) (
    input logic         clk,
    input logic         rst_n,
    spislaveio_if.slave bus
);
    state_t                 r_state;
    logic [7:0]             r_rxbuf, r_txbuf, r_txsh, r_rxsh, r_fill, r_bytecnt;
    logic [2:0]             r_bitcnt;
    logic                   r_rxf, r_txe, r_ovr, r_udr, r_eof;
    logic                   r_rxie, r_txie, r_eofie, r_en;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic w_ss_q, w_ss_rise, w_ss_fall, w_sck_unused, w_sck_rise, w_sck_fall;
    logic w_mosi, w_wr, w_rd_data, w_act, w_start, w_stop, w_run, w_bit, w_done, w_load, w_shift;
    logic [7:0] w_status, w_ctrl, w_rxbyte;

    syncedge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .i_d(bus.i_ss_n),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall));
    syncedge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .i_d(bus.i_sck),
        .o_q(w_sck_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_wr      = bus.i_cs & ~bus.i_rw;
    assign w_rd_data = bus.i_cs & bus.i_rw & (bus.i_ad == A_DATA);
    assign w_act     = (r_state == ACTIVE);
    assign w_start   = ~w_act & r_en & w_ss_fall;
    // Clearing EN mid-frame aborts quietly; only a real ss_n rise marks end of frame.
    assign w_stop    = w_act & (w_ss_rise | ~r_en);
    assign w_run     = w_act & ~w_stop;
    assign w_bit     = w_run & w_sck_rise;
    assign w_done    = w_bit & (r_bitcnt == 3'd7);
    assign w_load    = w_start | (w_run & w_sck_fall & (r_bitcnt == 3'd0));
    assign w_shift   = w_run & w_sck_fall & (r_bitcnt != 3'd0);
    assign w_rxbyte  = {r_rxsh[6:0], w_mosi};
    assign w_status  = {1'b0, r_eof, r_bitcnt != 3'd0, ~w_ss_q, r_udr, r_ovr, r_txe, r_rxf};
    assign w_ctrl    = {r_en, 4'b0000, r_eofie, r_txie, r_rxie};

    assign bus.o_do = (bus.i_ad == A_DATA)    ? r_rxbuf   :
                      (bus.i_ad == A_STATUS)  ? w_status  :
                      (bus.i_ad == A_CTRL)    ? w_ctrl    :
                      (bus.i_ad == A_FILL)    ? r_fill    :
                      (bus.i_ad == A_BYTECNT) ? r_bytecnt : 8'h00;
    assign bus.o_irq     = (r_rxie & r_rxf) | (r_txie & r_txe) | (r_eofie & r_eof);
    assign bus.o_miso    = r_txsh[7];
    assign bus.o_miso_oe = w_act;

    // Statement order encodes collision priority: clears before sets, load before DATA write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rxbuf     <= 8'h00;
            r_txbuf     <= 8'h00;
            r_txsh      <= 8'hFF;
            r_rxsh      <= 8'h00;
            r_fill      <= FILL_RESET;
            r_bytecnt   <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_rxf       <= 1'b0;
            r_txe       <= 1'b1;
            r_ovr       <= 1'b0;
            r_udr       <= 1'b0;
            r_eof       <= 1'b0;
            r_rxie      <= 1'b0;
            r_txie      <= 1'b0;
            r_eofie     <= 1'b0;
            r_en        <= 1'b0;
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
            if (w_wr && bus.i_ad == A_STATUS) begin
                if (bus.i_di[S_OVR]) r_ovr <= 1'b0;
                if (bus.i_di[S_UDR]) r_udr <= 1'b0;
                if (bus.i_di[S_EOF]) r_eof <= 1'b0;
            end
            if (w_wr && bus.i_ad == A_CTRL) begin
                r_rxie  <= bus.i_di[C_RXIE];
                r_txie  <= bus.i_di[C_TXIE];
                r_eofie <= bus.i_di[C_EOFIE];
                r_en    <= bus.i_di[C_EN];
            end
            if (w_wr && bus.i_ad == A_FILL) r_fill <= bus.i_di;
            if (w_rd_data) r_rxf <= 1'b0;
            if (w_start) begin
                r_state   <= ACTIVE;
                r_bitcnt  <= 3'd0;
                r_bytecnt <= 8'h00;
            end
            if (w_stop) begin
                r_state  <= IDLE;
                r_bitcnt <= 3'd0;
                if (w_ss_rise && r_en) r_eof <= 1'b1;
            end
            if (w_bit) begin
                r_rxsh   <= w_rxbyte;
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_done) begin
                if (!r_rxf || w_rd_data) begin
                    r_rxbuf <= w_rxbyte;
                    r_rxf   <= 1'b1;
                end else r_ovr <= 1'b1;
                if (r_bytecnt != 8'hFF) r_bytecnt <= r_bytecnt + 8'd1;
            end
            if (w_load) begin
                r_txsh <= r_txe ? r_fill : r_txbuf;
                r_txe  <= 1'b1;
                if (r_txe) r_udr <= 1'b1;
            end
            if (w_shift) r_txsh <= r_txsh << 1;
            if (w_wr && bus.i_ad == A_DATA) begin
                r_txbuf <= bus.i_di;
                r_txe   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spislaveio.sv
// tb_spislaveio: directed checks of spislaveio register bus, SPI frames and collision rules.
module tb_spislaveio;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [7:0] rx, rd, coll_rd;

    spislaveio_if bus ();
    spislaveio #(.SYNC_STAGES(2), .FILL_RESET(8'hFF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        bus.i_ad = a;
        bus.i_di = d;
        bus.i_rw = 1'b0;
        bus.i_cs = 1'b1;
        tick(1);
        bus.i_cs = 1'b0;
        bus.i_rw = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        bus.i_ad = a;
        bus.i_rw = 1'b1;
        bus.i_cs = 1'b1;
        #1 d = bus.o_do;
        tick(1);
        bus.i_cs = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        cpu_rd(a, d);
        chk(tag, {8'h00, d}, {8'h00, exp});
    endtask

    // Host side: data set on the low phase, miso sampled just before sck rises.
    task automatic host_bits(input logic [7:0] tx, input int n, input bit coll, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.i_mosi = tx[i];
            tick(6);
            r[i] = bus.o_miso;
            bus.i_sck = 1'b1;
            if (coll && i == 0) begin
                tick(3);
                bus.i_ad = 3'd0;
                bus.i_rw = 1'b1;
                bus.i_cs = 1'b1;
                #1 coll_rd = bus.o_do;
                tick(1);
                bus.i_cs = 1'b0;
                tick(2);
            end else tick(6);
            bus.i_sck = 1'b0;
        end
    endtask

    task automatic ss_lo();
        bus.i_ss_n = 1'b0;
        tick(8);
    endtask

    task automatic ss_hi();
        tick(6);
        bus.i_ss_n = 1'b1;
        tick(8);
    endtask

    initial begin
        bus.i_ad = 3'd0;
        bus.i_di = 8'h00;
        bus.i_rw = 1'b1;
        bus.i_cs = 1'b0;
        bus.i_ss_n = 1'b1;
        bus.i_sck = 1'b0;
        bus.i_mosi = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        // reset state
        rd_chk("rst_status", 3'd1, 8'h02);
        rd_chk("rst_fill", 3'd3, 8'hFF);
        rd_chk("rst_ctrl", 3'd2, 8'h00);
        rd_chk("rst_bytecnt", 3'd4, 8'h00);
        rd_chk("rst_reg6", 3'd6, 8'h00);
        chk("rst_miso_oe", {15'd0, bus.o_miso_oe}, 16'd0);
        chk("rst_irq", {15'd0, bus.o_irq}, 16'd0);
        chk("rst_miso", {15'd0, bus.o_miso}, 16'd1);
        // single byte exchange
        cpu_wr(3'd2, 8'h80);
        cpu_wr(3'd0, 8'hA5);
        rd_chk("f1_status_pre", 3'd1, 8'h00);
        ss_lo();
        chk("f1_miso_oe", {15'd0, bus.o_miso_oe}, 16'd1);
        rd_chk("f1_status_sel", 3'd1, 8'h12);
        host_bits(8'h3C, 8, 1'b0, rx);
        chk("f1_host_rx", {8'h00, rx}, 16'h00A5);
        ss_hi();
        rd_chk("f1_status_end", 3'd1, 8'h4B);
        chk("f1_miso_oe_end", {15'd0, bus.o_miso_oe}, 16'd0);
        rd_chk("f1_bytecnt", 3'd4, 8'h01);
        chk("f1_irq", {15'd0, bus.o_irq}, 16'd0);
        rd_chk("f1_rxbuf", 3'd0, 8'h3C);
        rd_chk("f1_status_rd", 3'd1, 8'h4A);
        cpu_wr(3'd1, 8'h48);
        rd_chk("f1_status_clr", 3'd1, 8'h02);
        // underrun with FILL, overrun on second byte
        cpu_wr(3'd3, 8'h5A);
        ss_lo();
        host_bits(8'h11, 8, 1'b0, rx);
        chk("f2_host_rx0", {8'h00, rx}, 16'h005A);
        host_bits(8'h77, 8, 1'b0, rx);
        chk("f2_host_rx1", {8'h00, rx}, 16'h005A);
        ss_hi();
        rd_chk("f2_status", 3'd1, 8'h4F);
        rd_chk("f2_bytecnt", 3'd4, 8'h02);
        cpu_wr(3'd1, 8'h04);
        rd_chk("f2_ovr_clr", 3'd1, 8'h4B);
        rd_chk("f2_rxbuf_keep", 3'd0, 8'h11);
        cpu_wr(3'd1, 8'h48);
        rd_chk("f2_status_clr", 3'd1, 8'h02);
        cpu_wr(3'd2, 8'h82);
        chk("txie_irq", {15'd0, bus.o_irq}, 16'd1);
        // aborted frame after 5 bits
        cpu_wr(3'd2, 8'h84);
        chk("eofie_irq_pre", {15'd0, bus.o_irq}, 16'd0);
        ss_lo();
        host_bits(8'hFF, 5, 1'b0, rx);
        ss_hi();
        rd_chk("f3_status", 3'd1, 8'h4A);
        chk("f3_irq", {15'd0, bus.o_irq}, 16'd1);
        rd_chk("f3_bytecnt", 3'd4, 8'h00);
        cpu_wr(3'd1, 8'h40);
        chk("f3_irq_clr", {15'd0, bus.o_irq}, 16'd0);
        rd_chk("f3_status_clr", 3'd1, 8'h0A);
        cpu_wr(3'd1, 8'h08);
        // byte completion on the same edge as a DATA read
        cpu_wr(3'd2, 8'h80);
        cpu_wr(3'd0, 8'hC3);
        ss_lo();
        host_bits(8'h81, 8, 1'b0, rx);
        chk("f4_host_rx0", {8'h00, rx}, 16'h00C3);
        host_bits(8'h7E, 8, 1'b1, rx);
        chk("f4_host_rx1", {8'h00, rx}, 16'h005A);
        chk("f4_coll_rd", {8'h00, coll_rd}, 16'h0081);
        ss_hi();
        rd_chk("f4_status", 3'd1, 8'h4B);
        rd_chk("f4_rxbuf", 3'd0, 8'h7E);
        cpu_wr(3'd1, 8'h48);
        rd_chk("f4_status_clr", 3'd1, 8'h02);
        // DATA write on the same edge as the frame-start load
        bus.i_ss_n = 1'b0;
        tick(3);
        cpu_wr(3'd0, 8'h96);
        tick(4);
        rd_chk("f5_status", 3'd1, 8'h18);
        host_bits(8'h00, 8, 1'b0, rx);
        chk("f5_host_rx0", {8'h00, rx}, 16'h005A);
        host_bits(8'h00, 8, 1'b0, rx);
        chk("f5_host_rx1", {8'h00, rx}, 16'h0096);
        ss_hi();
        // asynchronous reset mid-frame
        ss_lo();
        host_bits(8'hF0, 3, 1'b0, rx);
        chk("f6_miso_oe", {15'd0, bus.o_miso_oe}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("f6_rst_miso_oe", {15'd0, bus.o_miso_oe}, 16'd0);
        chk("f6_rst_irq", {15'd0, bus.o_irq}, 16'd0);
        bus.i_ad = 3'd1;
        #1;
        chk("f6_rst_status", {8'h00, bus.o_do}, 16'h0002);
        bus.i_ss_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        rd_chk("f6_ctrl", 3'd2, 8'h00);
        rd_chk("f6_fill", 3'd3, 8'hFF);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
